// File: rtl/demosaic_g_at_rb.sv
// G interpolation at R/B Bayer sites using gradient-directed Hamilton-Adams filtering.
// G sites pass the centre sample. Every output carries its site tag. Fixed 3-cycle latency.
module demosaic_g_at_rb #(
  parameter int unsigned Cols  = 562,
  parameter int unsigned Lines = 788,
  parameter int unsigned BAYER = 0
) (
  input  logic       INCLK,
  input  logic       RST,
  input  logic       SOF,
  input  logic       HSYNC,
  input  logic       IN_EN,
  input  logic [7:0] UU,
  input  logic [7:0] UP,
  input  logic [7:0] MID,
  input  logic [7:0] DOWN,
  input  logic [7:0] DD,
  input  logic [7:0] LL,
  input  logic [7:0] LEFT,
  input  logic [7:0] RIGHT,
  input  logic [7:0] RR,
  output logic [7:0] G_OUT,
  output logic [7:0] NAT_OUT,
  output logic [1:0] SITE,
  output logic       O_EN
);

  localparam int unsigned ColW = $clog2(Cols);
  localparam int unsigned RowW = $clog2(Lines);

  // Position tracking
  logic [ColW-1:0] r_col, w_col_nxt;
  logic [RowW-1:0] r_row, w_row_nxt;
  logic            r_hsync;
  logic            w_hs_fall;
  logic [1:0]      w_site;

  always_comb begin
    w_hs_fall = r_hsync & ~HSYNC;
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (SOF) begin
      w_row_nxt = '0;
      w_col_nxt = IN_EN ? ColW'(1) : '0;
    end else if (w_hs_fall) begin
      w_col_nxt = '0;
      w_row_nxt = (r_row == RowW'(Lines - 1)) ? '0 : r_row + RowW'(1);
    end else if (IN_EN) begin
      w_col_nxt = (r_col == ColW'(Cols - 1)) ? '0 : r_col + ColW'(1);
    end
    // A pixel arriving with SOF is treated as position (0,0).
    w_site = SOF ? 2'(BAYER) : ({r_row[0], r_col[0]} ^ 2'(BAYER));
  end

  always_ff @(posedge INCLK or posedge RST) begin
    if (RST) begin
      r_col   <= '0;
      r_row   <= '0;
      r_hsync <= 1'b0;
    end else begin
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_hsync <= HSYNC;
    end
  end

  // Stage 1: Laplacians, gradients and averages
  logic signed [10:0] w_mid_s, w_uu_s, w_up_s, w_down_s, w_dd_s;
  logic signed [10:0] w_ll_s, w_left_s, w_right_s, w_rr_s;
  logic signed [10:0] w_hlap, w_vlap, w_hd, w_vd;
  logic signed [10:0] w_hd_abs, w_vd_abs, w_hlap_abs, w_vlap_abs;
  logic signed [10:0] w_dh, w_dv;

  always_comb begin
    w_mid_s    = {3'b000, MID};
    w_uu_s     = {3'b000, UU};
    w_up_s     = {3'b000, UP};
    w_down_s   = {3'b000, DOWN};
    w_dd_s     = {3'b000, DD};
    w_ll_s     = {3'b000, LL};
    w_left_s   = {3'b000, LEFT};
    w_right_s  = {3'b000, RIGHT};
    w_rr_s     = {3'b000, RR};
    w_hlap     = (w_mid_s <<< 1) - w_ll_s - w_rr_s;
    w_vlap     = (w_mid_s <<< 1) - w_uu_s - w_dd_s;
    w_hd       = w_left_s - w_right_s;
    w_vd       = w_up_s - w_down_s;
    w_hd_abs   = w_hd[10] ? -w_hd : w_hd;
    w_vd_abs   = w_vd[10] ? -w_vd : w_vd;
    w_hlap_abs = w_hlap[10] ? -w_hlap : w_hlap;
    w_vlap_abs = w_vlap[10] ? -w_vlap : w_vlap;
    w_dh       = w_hd_abs + w_hlap_abs;
    w_dv       = w_vd_abs + w_vlap_abs;
  end

  logic               r_v1;
  logic [1:0]         r_site1;
  logic [7:0]         r_mid1;
  logic signed [10:0] r_hlap, r_vlap, r_dh, r_dv;
  logic [7:0]         r_havg, r_vavg, r_avg4;

  always_ff @(posedge INCLK or posedge RST) begin
    if (RST) begin
      r_v1    <= 1'b0;
      r_site1 <= '0;
      r_mid1  <= '0;
      r_hlap  <= '0;
      r_vlap  <= '0;
      r_dh    <= '0;
      r_dv    <= '0;
      r_havg  <= '0;
      r_vavg  <= '0;
      r_avg4  <= '0;
    end else begin
      r_v1    <= IN_EN;
      r_site1 <= w_site;
      r_mid1  <= MID;
      r_hlap  <= w_hlap;
      r_vlap  <= w_vlap;
      r_dh    <= w_dh;
      r_dv    <= w_dv;
      r_havg  <= 8'(({1'b0, LEFT} + {1'b0, RIGHT}) >> 1);
      r_vavg  <= 8'(({1'b0, UP} + {1'b0, DOWN}) >> 1);
      r_avg4  <= 8'(({2'b00, LEFT} + {2'b00, RIGHT} + {2'b00, UP} + {2'b00, DOWN}) >> 2);
    end
  end

  // Stage 2: pick the smoother direction; all-signed operands keep >>> arithmetic
  logic signed [11:0] w_hlap12, w_vlap12, w_lsum;
  logic signed [11:0] w_hsh, w_vsh, w_lsh;
  logic signed [11:0] w_havg12, w_vavg12, w_avg4_12;
  logic signed [11:0] w_g2;

  always_comb begin
    w_hlap12  = {r_hlap[10], r_hlap};
    w_vlap12  = {r_vlap[10], r_vlap};
    w_lsum    = w_hlap12 + w_vlap12;
    w_hsh     = w_hlap12 >>> 2;
    w_vsh     = w_vlap12 >>> 2;
    w_lsh     = w_lsum >>> 3;
    w_havg12  = {4'b0000, r_havg};
    w_vavg12  = {4'b0000, r_vavg};
    w_avg4_12 = {4'b0000, r_avg4};
    if (r_dh < r_dv) begin
      w_g2 = w_havg12 + w_hsh;
    end else if (r_dv < r_dh) begin
      w_g2 = w_vavg12 + w_vsh;
    end else begin
      w_g2 = w_avg4_12 + w_lsh;
    end
  end

  logic               r_v2;
  logic [1:0]         r_site2;
  logic [7:0]         r_mid2;
  logic signed [11:0] r_g2;

  always_ff @(posedge INCLK or posedge RST) begin
    if (RST) begin
      r_v2    <= 1'b0;
      r_site2 <= '0;
      r_mid2  <= '0;
      r_g2    <= '0;
    end else begin
      r_v2    <= r_v1;
      r_site2 <= r_site1;
      r_mid2  <= r_mid1;
      r_g2    <= w_g2;
    end
  end

  // Stage 3: clamp, G-site bypass, zero data when invalid
  logic [7:0] w_clamp;
  logic       w_g_site;

  always_comb begin
    if (r_g2[11]) begin
      w_clamp = 8'd0;
    end else if (|r_g2[10:8]) begin
      w_clamp = 8'hff;
    end else begin
      w_clamp = r_g2[7:0];
    end
    w_g_site = r_site2[0] ^ r_site2[1];
  end

  always_ff @(posedge INCLK or posedge RST) begin
    if (RST) begin
      O_EN    <= 1'b0;
      G_OUT   <= '0;
      NAT_OUT <= '0;
      SITE    <= '0;
    end else begin
      O_EN    <= r_v2;
      G_OUT   <= r_v2 ? (w_g_site ? r_mid2 : w_clamp) : 8'd0;
      NAT_OUT <= r_v2 ? r_mid2 : 8'd0;
      SITE    <= r_v2 ? r_site2 : 2'd0;
    end
  end

endmodule

// File: tb/tb_demosaic_g_at_rb.sv
// Bench for demosaic_g_at_rb: directed vectors plus randomized windows against an
// integer-arithmetic reference with a 3-deep expected-output delay line.
module tb_demosaic_g_at_rb;

  localparam int Cols  = 562;
  localparam int Lines = 788;
  localparam int Bayer = 0;

  logic       INCLK = 1'b0;
  logic       RST, SOF, HSYNC, IN_EN;
  logic [7:0] UU, UP, MID, DOWN, DD, LL, LEFT, RIGHT, RR;
  logic [7:0] G_OUT, NAT_OUT;
  logic [1:0] SITE;
  logic       O_EN;

  demosaic_g_at_rb #(.Cols(Cols), .Lines(Lines), .BAYER(Bayer)) dut (
    .INCLK(INCLK), .RST(RST), .SOF(SOF), .HSYNC(HSYNC), .IN_EN(IN_EN),
    .UU(UU), .UP(UP), .MID(MID), .DOWN(DOWN), .DD(DD),
    .LL(LL), .LEFT(LEFT), .RIGHT(RIGHT), .RR(RR),
    .G_OUT(G_OUT), .NAT_OUT(NAT_OUT), .SITE(SITE), .O_EN(O_EN)
  );

  always #5 INCLK = ~INCLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_row, m_col;
  bit          m_prev_hs;
  logic [18:0] m_pipe [3];

  // Expected {valid, site, native, g} from the interpolation rules in plain integers.
  function automatic logic [18:0] ref_pixel(input int site, input int uu, input int up,
                                            input int mid, input int dn, input int dd,
                                            input int ll, input int l, input int r,
                                            input int rr);
    int hl, vl, dh, dv, g;
    hl = 2 * mid - ll - rr;
    vl = 2 * mid - uu - dd;
    dh = ((l - r) < 0 ? r - l : l - r) + (hl < 0 ? -hl : hl);
    dv = ((up - dn) < 0 ? dn - up : up - dn) + (vl < 0 ? -vl : vl);
    if (dh < dv) g = (l + r) / 2 + (hl >>> 2);
    else if (dv < dh) g = (up + dn) / 2 + (vl >>> 2);
    else g = (l + r + up + dn) / 4 + ((hl + vl) >>> 3);
    if (g < 0) g = 0;
    if (g > 255) g = 255;
    if (site == 1 || site == 2) g = mid;
    return {1'b1, 2'(site), 8'(mid), 8'(g)};
  endfunction

  // One clock: drive controls at negedge, advance the model, return #1 after posedge.
  task automatic step(input bit rst, input bit sof, input bit hs, input bit en);
    int          r, c;
    logic [18:0] e;
    @(negedge INCLK);
    RST = rst; SOF = sof; HSYNC = hs; IN_EN = en;
    if (rst) begin
      m_pipe = '{default: '0};
      m_row = 0; m_col = 0; m_prev_hs = 1'b0;
    end else begin
      r = sof ? 0 : m_row;
      c = sof ? 0 : m_col;
      e = en ? ref_pixel(((r % 2) * 2 + (c % 2)) ^ Bayer, UU, UP, MID, DOWN, DD,
                         LL, LEFT, RIGHT, RR) : 19'd0;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = e;
      if (sof) begin
        m_row = 0; m_col = en ? 1 : 0;
      end else if (m_prev_hs && !hs) begin
        m_col = 0; m_row = (m_row + 1) % Lines;
      end else if (en) begin
        m_col = (m_col + 1) % Cols;
      end
      m_prev_hs = hs;
    end
    @(posedge INCLK);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    UU = v; UP = v; MID = v; DOWN = v; DD = v; LL = v; LEFT = v; RIGHT = v; RR = v;
  endtask

  task automatic rand_taps();
    UU = 8'($urandom); UP = 8'($urandom); MID = 8'($urandom); DOWN = 8'($urandom);
    DD = 8'($urandom); LL = 8'($urandom); LEFT = 8'($urandom); RIGHT = 8'($urandom);
    RR = 8'($urandom);
    // Mirrored taps give dH == dV and exercise the blended path.
    if ($urandom_range(3) == 0) begin
      UP = LEFT; DOWN = RIGHT; UU = LL; DD = RR;
    end
  endtask

  task automatic test_reset();
    set_all(8'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_checks++;
    if ({O_EN, SITE, NAT_OUT, G_OUT} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {O_EN, SITE, NAT_OUT, G_OUT});
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_flat();
    set_all(8'd100);
    step(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      n_checks++;
      if ({O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
        n_fail++;
        $display("FAIL flat_model c%0d: got %h want %h", i, {O_EN, SITE, NAT_OUT, G_OUT},
                 m_pipe[2]);
      end
      if (i == 1) begin
        n_checks++;
        if (O_EN !== 1'b1 || G_OUT !== 8'd100 || NAT_OUT !== 8'd100 || SITE !== 2'd0) begin
          n_fail++;
          $display("FAIL flat_field: got en=%b g=%0d nat=%0d site=%0d want 1 100 100 0",
                   O_EN, G_OUT, NAT_OUT, SITE);
        end
      end
    end
  endtask

  task automatic test_edges_and_clamp();
    logic [7:0] want [3];
    want[0] = 8'd120; want[1] = 8'd255; want[2] = 8'd0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          LL = 50; LEFT = 50; RIGHT = 200; RR = 200;
          UU = 120; UP = 120; MID = 120; DOWN = 120; DD = 120;
        end
        1: begin
          LL = 0; RR = 0; UU = 0; DD = 0; LEFT = 250; RIGHT = 250;
          UP = 0; DOWN = 255; MID = 255;
        end
        default: begin
          MID = 0; LL = 255; RR = 255; UU = 255; DD = 255; LEFT = 10; RIGHT = 10;
          UP = 0; DOWN = 255;
        end
      endcase
      step(0, 1, 1, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      n_checks++;
      if (O_EN !== 1'b1 || G_OUT !== want[k] || {O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
        n_fail++;
        $display("FAIL edge_clamp%0d: got en=%b g=%0d want 1 %0d (model %h)", k, O_EN, G_OUT,
                 want[k], m_pipe[2]);
      end
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_sites();
    logic [1:0] exp_s [8];
    logic [1:0] got_s [8];
    logic [7:0] g_gr;
    int         n;
    exp_s = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    n = 0;
    g_gr = 8'd0;
    for (int i = 0; i < 14; i++) begin
      rand_taps();
      if (i == 1) MID = 8'd77;
      if (i == 0) step(0, 1, 1, 1);
      else if (i < 4) step(0, 0, 1, 1);
      else if (i == 4) step(0, 0, 0, 0);
      else if (i < 9) step(0, 0, 1, 1);
      else step(0, 0, 1, 0);
      n_checks++;
      if ({O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
        n_fail++;
        $display("FAIL sites_model c%0d: got %h want %h", i, {O_EN, SITE, NAT_OUT, G_OUT},
                 m_pipe[2]);
      end
      if (O_EN === 1'b1) begin
        if (n < 8) got_s[n] = SITE;
        if (n == 1) g_gr = G_OUT;
        n++;
      end
    end
    n_checks++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL sites_count: got %0d want 8", n);
    end
    for (int j = 0; j < 8 && j < n; j++) begin
      n_checks++;
      if (got_s[j] !== exp_s[j]) begin
        n_fail++;
        $display("FAIL site_seq%0d: got %0d want %0d", j, got_s[j], exp_s[j]);
      end
    end
    n_checks++;
    if (g_gr !== 8'd77) begin
      n_fail++;
      $display("FAIL gr_passthru: got %0d want 77", g_gr);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] pat;
    pat = '0;
    for (int i = 1; i <= 11; i++) begin
      rand_taps();
      if (i == 1) step(0, 1, 1, 1);
      else if (i == 4 || i == 5 || i >= 9) step(0, 0, 1, 0);
      else step(0, 0, 1, 1);
      n_checks++;
      if ({O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
        n_fail++;
        $display("FAIL bubble_model c%0d: got %h want %h", i, {O_EN, SITE, NAT_OUT, G_OUT},
                 m_pipe[2]);
      end
      if (i >= 3 && i <= 10) pat = {pat[6:0], O_EN};
    end
    n_checks++;
    if (pat !== 8'b11100111) begin
      n_fail++;
      $display("FAIL bubble_oen: got %b want 11100111", pat);
    end
  endtask

  task automatic test_random();
    int len;
    for (int ln = 0; ln < 7; ln++) begin
      len = (ln == 3) ? Cols + 3 : int'($urandom_range(40, 5));
      for (int p = 0; p < len; p++) begin
        rand_taps();
        if (ln == 0 && p == 0) step(0, 1, 1, 1);
        else step(0, 0, 1, ($urandom_range(3) != 0));
        n_checks++;
        if ({O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
          n_fail++;
          $display("FAIL random l%0d p%0d: got %h want %h", ln, p,
                   {O_EN, SITE, NAT_OUT, G_OUT}, m_pipe[2]);
        end
      end
      step(0, 0, 0, 0);
      n_checks++;
      if ({O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
        n_fail++;
        $display("FAIL random_eol l%0d: got %h want %h", ln, {O_EN, SITE, NAT_OUT, G_OUT},
                 m_pipe[2]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int n_en;
    n_en = 0;
    rand_taps();
    step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    @(negedge INCLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if ({O_EN, SITE, NAT_OUT, G_OUT} !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %h want 0", {O_EN, SITE, NAT_OUT, G_OUT});
    end
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      if (O_EN !== 1'b0) n_en++;
    end
    n_checks++;
    if (n_en != 0) begin
      n_fail++;
      $display("FAIL rst_flush: got %0d O_EN cycles want 0", n_en);
    end
    rand_taps();
    step(0, 1, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if (O_EN !== 1'b1 || SITE !== 2'd0 || {O_EN, SITE, NAT_OUT, G_OUT} !== m_pipe[2]) begin
      n_fail++;
      $display("FAIL rst_restart: got en=%b site=%0d want 1 0", O_EN, SITE);
    end
  endtask

  initial begin
    RST = 1'b1; SOF = 1'b0; HSYNC = 1'b0; IN_EN = 1'b0;
    m_pipe = '{default: '0};
    m_row = 0; m_col = 0; m_prev_hs = 1'b0;
    test_reset();
    test_flat();
    test_edges_and_clamp();
    test_sites();
    test_bubbles();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
